// File: rtl/seq_mul_pkg.sv
// ============================================================================
// Module   : seq_mul_pkg
// Purpose  : Shared state encoding and width-generic helpers for seq_mul_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul_pkg;

    localparam int MAX_W = 64;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return mask;
    endfunction

    // Most-negative input maps to 2^(w-1), which still fits w unsigned bits.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] value,
                                                 input int unsigned     w,
                                                 input logic            signed_flag);
        logic [MAX_W-1:0] res;
        if (signed_flag && value[IDX_W'(w - 1)]) begin
            res = (~value + MAX_W'(1)) & width_mask(w);
        end else begin
            res = value & width_mask(w);
        end
        return res;
    endfunction

    function automatic logic [MAX_W-1:0] neg2w(input logic [MAX_W-1:0] value,
                                               input int unsigned     w);
        logic [MAX_W-1:0] res;
        res = (~value + MAX_W'(1)) & width_mask(w);
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mul_param_if.sv
// ============================================================================
// Module   : seq_mul_param_if
// Purpose  : Load/ready request and valid/ack result bundle of seq_mul_param.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mul_param_if #(
    parameter int WIDTH = 4
) ();
    logic               load;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               ack_in;
    logic [2*WIDTH-1:0] op;
    logic               ready_out;
    logic               valid_out;
    logic               busy_out;

    modport master (
        output load, a, b, signed_mode, ack_in,
        input  op, ready_out, valid_out, busy_out
    );

    modport slave (
        input  load, a, b, signed_mode, ack_in,
        output op, ready_out, valid_out, busy_out
    );
endinterface

`default_nettype wire

// File: rtl/seq_mul_dp.sv
// ============================================================================
// Module   : seq_mul_dp
// Purpose  : Shift-add datapath (accumulator, shifters, counter, sign flag).
//            Macro EARLY_TERM_EN: finish once the multiplier runs out of ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_dp
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_a,
    input  wire logic               start,
    input  wire logic               step,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    input  wire logic               signed_mode,
    output logic                    last,
    output logic [2*WIDTH-1:0]      prod
);
    localparam int              PW       = 2 * WIDTH;
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_mplier_shift;

    assign w_abs_a        = WIDTH'(abs_val(MAX_W'(a), WIDTH, signed_mode));
    assign w_abs_b        = WIDTH'(abs_val(MAX_W'(b), WIDTH, signed_mode));
    assign w_mplier_shift = mplier_q >> 1;

    // Multiplicand is pre-shifted each step, equivalent to shifting by the counter.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        if (start) begin
            mcand_d  = PW'(w_abs_a);
            mplier_d = w_abs_b;
            acc_d    = '0;
            cnt_d    = '0;
            neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = w_mplier_shift;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

`ifdef EARLY_TERM_EN
    assign last = step && ((cnt_q == CNT_LAST) || (w_mplier_shift == '0));
`else
    assign last = step && (cnt_q == CNT_LAST);
`endif

    // Signed result is taken from the accumulator value being written this edge.
    assign prod = neg_q ? PW'(neg2w(MAX_W'(acc_d), PW)) : acc_d;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_mul_param.sv
// ============================================================================
// Module   : seq_mul_param
// Purpose  : Parametrised sequential shift-add multiplier, unsigned or signed.
//            Optional macro EARLY_TERM_EN shortens CALC for small multipliers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_param
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_a,
    seq_mul_param_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    state_e         state_q, state_d;
    logic [PW-1:0]  op_q, op_d;
    logic           ready_q, ready_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    logic           w_start;
    logic           w_step;
    logic           w_last;
    logic [PW-1:0]  w_prod;

    assign w_start = (state_q == IDLE) && bus.load;
    assign w_step  = (state_q == CALC);

    seq_mul_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk         (clk),
        .rst_a       (rst_a),
        .start       (w_start),
        .step        (w_step),
        .a           (bus.a),
        .b           (bus.b),
        .signed_mode (bus.signed_mode),
        .last        (w_last),
        .prod        (w_prod)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (bus.load) state_d = CALC;
            CALC: begin
                if (w_last) begin
                    state_d = DONE;
                    op_d    = w_prod;
                end
            end
            DONE: if (bus.ack_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next state.
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == CALC);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= IDLE;
            op_q    <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.op        = op_q;
    assign bus.ready_out = ready_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out  = busy_q;

endmodule

`default_nettype wire

// File: doc/seq_mul_param.md
Name: seq_mul_param

Overview:
Parametrised shift-add sequential multiplier, successor to the fixed 4-bit seq_mul. Multiplies two WIDTH-bit operands, unsigned or two's-complement (selected per operation), one multiplier bit per clock. Uses a load/ready request side and a valid/ack result side, so it sits between a register-file or datapath controller and a consumer that may stall.

Parameters:
WIDTH, 4, operand width in bits (>=2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH) (localparam), iteration counter width.

Ports:
clk  input  1  clock, rising edge.
rst_a  input  1  asynchronous reset, active-low.
load  input  1  start request; accepted only when ready_out=1.
a  input  WIDTH  multiplicand, captured on the accepting edge.
b  input  WIDTH  multiplier, captured on the accepting edge.
signed_mode  input  1  1 = two's-complement operands; captured with a/b.
ack_in  input  1  consumer accepts result; meaningful while valid_out=1.
op  output  2*WIDTH  product; stable while valid_out=1.
ready_out  output  1  block idle, can accept load.
valid_out  output  1  op holds a completed product.
busy_out  output  1  iteration in progress.

Behaviour:
- Reset (rst_a=0, async): state=IDLE, op=0, ready_out=1, valid_out=0, busy_out=0; internal accumulator/counter/sign flag cleared. Reset mid-CALC or mid-DONE aborts the operation, and no result is produced.
- FSM IDLE -> CALC -> DONE -> IDLE. All outputs are registered.
- IDLE: ready_out=1. On an edge with load=1:
  - latch |a| and |b| (absolute values if signed_mode=1, raw otherwise);
  - latch neg = signed_mode & (a[MSB]^b[MSB]);
  - clear accumulator and counter; go to CALC.
- Absolute value of the most-negative operand (e.g. -8 at WIDTH=4) is held as unsigned 2^(WIDTH-1); no overflow.
- CALC: busy_out=1, ready_out=0. Each cycle:
  - if multiplier LSB=1, add the multiplicand shifted by the counter into the 2*WIDTH accumulator;
  - shift the multiplier right; increment the counter.
  - After WIDTH cycles go to DONE. On the DONE entry edge, op = neg ? -acc : acc (2*WIDTH-bit two's-complement negate).
- Latency: valid_out rises exactly WIDTH clock edges after the accepting edge.
- DONE: valid_out=1; op is held. On an edge with ack_in=1, go to IDLE: valid_out=0, ready_out=1 next cycle, op keeps its last value.
- load is ignored outside IDLE, including when load and ack_in are both high in DONE. A new load is accepted one cycle after ack at the earliest.
- ack_in is ignored outside DONE.
- Unsigned mode: result is always exact (max (2^W-1)^2). Signed mode: result is exact over the full range, including (-2^(W-1))^2.

Optional Feature:
EARLY_TERM_EN
- Defined: CALC exits to DONE on the edge where the shifted multiplier becomes zero, or when the counter reaches WIDTH, whichever comes first. Minimum one CALC cycle, so b=0 or b=1 gives valid_out one edge after accept. Product is identical to the full-length run.
- Undefined: fixed WIDTH-cycle latency as above.

Decomposition:
- Package seq_mul_pkg:
  - state enum (IDLE, CALC, DONE);
  - function abs_val(value, signed_flag);
  - function neg2w for the product negate.
- One sub-module, seq_mul_dp: the datapath (accumulator, multiplicand/multiplier shifters, counter), steered by the FSM in the top.

Test Plan:
- WIDTH=4, unsigned, a=2, b=3, load for 1 cycle -> valid_out after 4 edges, op=8'h06; hold ack_in=0 for 3 cycles -> op stays 06; ack -> ready_out=1.
- WIDTH=4, unsigned, 3*3 -> 8'h09; 15*15 -> 8'hE1; 0*9 -> 8'h00.
- WIDTH=4, signed: -3*5 -> 8'hF1; -8*-8 -> 8'h40; -8*7 -> 8'hC8; 7*-1 -> 8'hF9.
- Apply load while busy_out=1 with different a/b -> ignored, original product returned. load and ack_in high together in DONE -> only ack taken.
- Drop rst_a mid-CALC (cycle 2) -> outputs reset immediately, no valid_out. Next load of 5*5 after release -> 8'h19.
- EARLY_TERM_EN, WIDTH=8: b=0 -> valid_out 1 edge after accept; b=8'h04 -> 3 edges; b=8'h80 -> 8 edges. Products match the non-early build for 1000 random signed/unsigned pairs.
